// File: rtl/sad_array.sv
`default_nettype none
// ============================================================================
//  Module   : sad_array
//  Function : Streams in a 4x4 current block and a 7x7 search window, then
//             computes all 16 candidate SADs in parallel over 16 cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module sad_array #(
   parameter int PIX_W = 8,
   parameter int SUM_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   output logic [SUM_W-1:0] sum0,
   output logic [SUM_W-1:0] sum1,
   output logic [SUM_W-1:0] sum2,
   output logic [SUM_W-1:0] sum3,
   output logic [SUM_W-1:0] sum4,
   output logic [SUM_W-1:0] sum5,
   output logic [SUM_W-1:0] sum6,
   output logic [SUM_W-1:0] sum7,
   output logic [SUM_W-1:0] sum8,
   output logic [SUM_W-1:0] sum9,
   output logic [SUM_W-1:0] sum10,
   output logic [SUM_W-1:0] sum11,
   output logic [SUM_W-1:0] sum12,
   output logic [SUM_W-1:0] sum13,
   output logic [SUM_W-1:0] sum14,
   output logic [SUM_W-1:0] sum15,
   output logic             sum_valid,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_LOAD_CUR = 2'd0,
      S_LOAD_WIN = 2'd1,
      S_CALC     = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   localparam logic [3:0] c_last_cur = 4'd15;
   localparam logic [5:0] c_last_win = 6'd48;
   localparam logic [3:0] c_last_p   = 4'd15;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_cur_cnt;
   logic [5:0]       r_win_cnt;
   logic [3:0]       r_p;
   logic             r_sum_valid;
   logic [PIX_W-1:0] r_cur [0:15];
   logic [PIX_W-1:0] r_win [0:48];
   logic             w_xfer;
   logic             w_win_done;
   logic             w_calc_last;
   logic [PIX_W-1:0] w_cur_pix;

   assign w_xfer      = in_valid && in_ready;
   assign w_win_done  = w_xfer && (r_state == S_LOAD_WIN) && (r_win_cnt == c_last_win);
   assign w_calc_last = (r_state == S_CALC) && (r_p == c_last_p);
   assign w_cur_pix   = r_cur[r_p];

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_LOAD_CUR: begin
            in_ready = !rst;
            if (w_xfer && (r_cur_cnt == c_last_cur))
               w_state_nxt = S_LOAD_WIN;
         end
         S_LOAD_WIN: begin
            in_ready = !rst;
            if (w_win_done)
               w_state_nxt = S_CALC;
         end
         S_CALC: begin
            busy = 1'b1;
            if (r_p == c_last_p)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy        = 1'b1;
            w_state_nxt = S_LOAD_CUR;
         end
         default: w_state_nxt = S_LOAD_CUR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_LOAD_CUR;
         r_cur_cnt   <= '0;
         r_win_cnt   <= '0;
         r_p         <= '0;
         r_sum_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sum_valid <= (w_state_nxt == S_DONE);
         if (w_xfer && (r_state == S_LOAD_CUR))
            r_cur_cnt <= r_cur_cnt + 4'd1;
         if (w_xfer && (r_state == S_LOAD_WIN))
            r_win_cnt <= w_win_done ? 6'd0 : r_win_cnt + 6'd1;
         if (w_win_done)
            r_p <= '0;
         else if (r_state == S_CALC)
            r_p <= r_p + 4'd1;
      end
   end

   // Pixel buffers carry no reset: stale content is always overwritten before use.
   always_ff @(posedge clk) begin
      if (w_xfer && (r_state == S_LOAD_CUR))
         r_cur[r_cur_cnt] <= in_pixel;
      if (w_xfer && (r_state == S_LOAD_WIN))
         r_win[r_win_cnt] <= in_pixel;
   end

   for (genvar k = 0; k < 16; k++) begin : g_pe
      localparam int DY = k / 4;
      localparam int DX = k % 4;
      logic [5:0]       w_idx;
      logic [PIX_W-1:0] w_win_pix;
      logic [PIX_W-1:0] w_diff;
      logic [SUM_W-1:0] w_add;
      logic [SUM_W-1:0] r_acc;
      logic [SUM_W-1:0] r_sum;

      assign w_idx     = 6'(7 * (int'(r_p[3:2]) + DY) + int'(r_p[1:0]) + DX);
      assign w_win_pix = r_win[w_idx];
      assign w_diff    = (w_cur_pix >= w_win_pix) ? (w_cur_pix - w_win_pix)
                                                  : (w_win_pix - w_cur_pix);
      assign w_add     = r_acc + SUM_W'(w_diff);

      always_ff @(posedge clk) begin
         if (rst) begin
            r_acc <= '0;
            r_sum <= '0;
         end else if (w_win_done) begin
            r_acc <= '0;
         end else if (r_state == S_CALC) begin
            r_acc <= w_add;
            if (w_calc_last)
               r_sum <= w_add;
         end
      end
   end

   assign sum_valid = r_sum_valid;
   assign sum0  = g_pe[0].r_sum;
   assign sum1  = g_pe[1].r_sum;
   assign sum2  = g_pe[2].r_sum;
   assign sum3  = g_pe[3].r_sum;
   assign sum4  = g_pe[4].r_sum;
   assign sum5  = g_pe[5].r_sum;
   assign sum6  = g_pe[6].r_sum;
   assign sum7  = g_pe[7].r_sum;
   assign sum8  = g_pe[8].r_sum;
   assign sum9  = g_pe[9].r_sum;
   assign sum10 = g_pe[10].r_sum;
   assign sum11 = g_pe[11].r_sum;
   assign sum12 = g_pe[12].r_sum;
   assign sum13 = g_pe[13].r_sum;
   assign sum14 = g_pe[14].r_sum;
   assign sum15 = g_pe[15].r_sum;

endmodule
`default_nettype wire
